// File: rtl/inv_share_arbiter.sv
// Round-robin arbiter sharing one bitwise-inversion unit among N requesters.
// One operation at a time: grant, occupy the inverter for EXEC_CYCLES, present the result.
module inv_share_arbiter #(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [$clog2(N)-1:0] resp_id,
    output logic [W-1:0]         resp_data
);

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_gnt;
    logic [W-1:0]     r_data_q;
    logic             r_resp_valid;
    logic [ID_W-1:0]  r_resp_id;
    logic [W-1:0]     r_resp_data;

    logic [ID_W:0]    w_pick;
    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [N-1:0]     w_onehot;
    logic             w_launch;
    logic             w_finish;
    logic [W-1:0]     w_ops [N];

    // Search ptr+1, ptr+2, ... mod N; iterating from the far end lets the nearest hit win.
    function automatic logic [ID_W:0] f_pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx_l;
        int              idx;
        res = '0;
        for (int off = N; off >= 1; off--) begin
            idx   = (int'(p) + off) % N;
            idx_l = ID_W'(idx);
            if (r[idx_l]) begin
                res = {1'b1, idx_l};
            end
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_ops
        assign w_ops[gi] = req_data[gi*W +: W];
    end

    assign w_pick   = f_pick(req, r_ptr);
    assign w_found  = w_pick[ID_W];
    assign w_winner = w_pick[ID_W-1:0];
    assign w_onehot = N'(1) << w_winner;
    assign w_launch = (r_state == ST_IDLE) && w_found;
    assign w_finish = (r_state == ST_EXEC) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nxt = ST_EXEC;
            ST_EXEC: if (r_cnt == '0) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration pointer, occupancy counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= ID_W'(N - 1);
            r_cnt        <= '0;
            r_gnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
        end else begin
            r_gnt        <= '0;
            r_resp_valid <= 1'b0;
            if (w_launch) begin
                r_gnt <= w_onehot;
                r_ptr <= w_winner;
                r_cnt <= CNT_W'(EXEC_CYCLES - 1);
            end else if (w_finish) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_ptr;
                r_resp_data  <= ~r_data_q;
            end else if (r_state == ST_EXEC) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Operand is captured only at grant, so later req_data changes cannot leak in.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_data_q <= w_ops[w_winner];
        end
    end

    assign gnt        = r_gnt;
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_inv_share_arbiter.sv
// Directed bench for inv_share_arbiter: three instances cover EXEC_CYCLES of 2, 4 and 1.
module tb_inv_share_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, rst4, rst1;
    logic [3:0]  req2, req4, req1;
    logic [31:0] dat2, dat4, dat1;
    logic [3:0]  gnt2, gnt4, gnt1;
    logic        busy2, busy4, busy1;
    logic        rv2, rv4, rv1;
    logic [1:0]  id2, id4, id1;
    logic [7:0]  rd2, rd4, rd1;

    int n_checks = 0;
    int n_fail   = 0;

    inv_share_arbiter #(.N(4), .W(8), .EXEC_CYCLES(2)) u_dut_e2 (
        .clk(clk), .rst(rst2), .req(req2), .req_data(dat2), .gnt(gnt2), .busy(busy2),
        .resp_valid(rv2), .resp_id(id2), .resp_data(rd2));

    inv_share_arbiter #(.N(4), .W(8), .EXEC_CYCLES(4)) u_dut_e4 (
        .clk(clk), .rst(rst4), .req(req4), .req_data(dat4), .gnt(gnt4), .busy(busy4),
        .resp_valid(rv4), .resp_id(id4), .resp_data(rd4));

    inv_share_arbiter #(.N(4), .W(8), .EXEC_CYCLES(1)) u_dut_e1 (
        .clk(clk), .rst(rst1), .req(req1), .req_data(dat1), .gnt(gnt1), .busy(busy1),
        .resp_valid(rv1), .resp_id(id1), .resp_data(rd1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2i(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One complete operation on the EXEC_CYCLES=2 instance; dat_late replaces the operands after grant.
    task automatic e2_op(input string tag, input logic [3:0] rq, input logic [31:0] dat,
                         input logic [31:0] dat_late, input logic [3:0] exp_gnt,
                         input int exp_id, input logic [7:0] exp_dat);
        req2 = rq;
        dat2 = dat;
        tick();
        check({tag, "_gnt"}, gnt2, exp_gnt);
        check({tag, "_busy_k"}, busy2, 1);
        req2 = '0;
        dat2 = dat_late;
        tick();
        check({tag, "_gnt_clear"}, gnt2, 0);
        check({tag, "_rv_early"}, rv2, 0);
        check({tag, "_busy_k1"}, busy2, 1);
        tick();
        check({tag, "_rv"}, rv2, 1);
        check({tag, "_id"}, id2, exp_id);
        check({tag, "_data"}, rd2, exp_dat);
        check({tag, "_busy_k2"}, busy2, 1);
        tick();
        check({tag, "_rv_drop"}, rv2, 0);
        check({tag, "_busy_k3"}, busy2, 0);
        check({tag, "_data_hold"}, rd2, exp_dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_id[8], g_cyc[8], r_id[8], r_dat[8], r_cyc[8];
        int ng, nr, lat, cnt_rv, cnt_busy, consec;
        logic prev;
        int exp_rr_id[5];
        int exp_rr_dat[5];
        exp_rr_id  = '{0, 1, 2, 3, 0};
        exp_rr_dat = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'hFF};

        rst2 = 1; rst4 = 1; rst1 = 1;
        req2 = 0; req4 = 0; req1 = 0;
        dat2 = 0; dat4 = 0; dat1 = 0;
        tick();
        tick();
        check("rst_gnt", gnt2, 0);
        check("rst_busy", busy2, 0);
        check("rst_rv", rv2, 0);
        check("rst_id", id2, 0);
        check("rst_data", rd2, 0);
        check("rst_busy_e4", busy4, 0);
        check("rst_busy_e1", busy1, 0);
        rst2 = 0; rst4 = 0; rst1 = 0;
        repeat (3) tick();
        check("idle_gnt", gnt2, 0);
        check("idle_busy", busy2, 0);

        // Single request
        e2_op("single", 4'b0001, 32'h0000_00A5, 32'h0000_00A5, 4'b0001, 0, 8'h5A);

        // Continuous round-robin from a fresh pointer
        rst2 = 1;
        tick();
        rst2 = 0;
        req2 = 4'hF;
        dat2 = 32'hF00F_FF00;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 40 && nr < 5; c++) begin
            tick();
            if (gnt2 != 0 && ng < 8) begin
                check("rr_onehot", $countones(gnt2), 1);
                g_id[ng]  = oh2i(gnt2);
                g_cyc[ng] = c;
                ng++;
                if (ng == 5) req2 = '0;
            end
            if (rv2 && nr < 8) begin
                r_id[nr]  = id2;
                r_dat[nr] = rd2;
                r_cyc[nr] = c;
                nr++;
            end
        end
        tick();
        check("rr_grants", ng, 5);
        check("rr_results", nr, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) check($sformatf("rr_gnt_id%0d", i), g_id[i], exp_rr_id[i]);
            if (i < nr) begin
                check($sformatf("rr_res_id%0d", i), r_id[i], exp_rr_id[i]);
                check($sformatf("rr_res_dat%0d", i), r_dat[i], exp_rr_dat[i]);
            end
            if (i < ng && i < nr) check($sformatf("rr_lat%0d", i), r_cyc[i] - g_cyc[i], 2);
            if (i > 0 && i < ng) check($sformatf("rr_gap%0d", i), g_cyc[i] - g_cyc[i-1], 4);
        end

        // Wrap-around: last winner was 0
        e2_op("wrap_a", 4'b1000, 32'h1100_0000, 32'h1100_0000, 4'b1000, 3, 8'hEE);
        e2_op("wrap_b", 4'b1010, 32'h9900_2200, 32'h9900_2200, 4'b0010, 1, 8'hDD);
        e2_op("wrap_c", 4'b1000, 32'h8000_0000, 32'h8000_0000, 4'b1000, 3, 8'h7F);

        // Late operand change after grant
        e2_op("late", 4'b0100, 32'h003C_0000, 32'h0000_0000, 4'b0100, 2, 8'hC3);

        // EXEC_CYCLES=4: one full operation, then reset mid-EXEC
        req4 = 4'b0100;
        dat4 = 32'h0081_0000;
        tick();
        check("e4a_gnt", gnt4, 4'b0100);
        req4 = '0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (rv4) begin
                lat = c;
                break;
            end
        end
        check("e4a_lat", lat, 4);
        check("e4a_id", id4, 2);
        check("e4a_data", rd4, 8'h7E);
        tick();
        check("e4a_idle", busy4, 0);

        req4 = 4'b0001;
        dat4 = 32'h0000_0033;
        tick();
        check("e4b_gnt", gnt4, 4'b0001);
        req4 = '0;
        tick();
        rst4 = 1;
        tick();
        rst4 = 0;
        check("mid_rst_gnt", gnt4, 0);
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_rv", rv4, 0);
        check("mid_rst_id", id4, 0);
        check("mid_rst_data", rd4, 0);
        cnt_rv = 0;
        cnt_busy = 0;
        repeat (6) begin
            tick();
            if (rv4) cnt_rv++;
            if (busy4) cnt_busy++;
        end
        check("mid_rst_no_rv", cnt_rv, 0);
        check("mid_rst_no_busy", cnt_busy, 0);
        req4 = 4'b0110;
        dat4 = 32'h0000_C300;
        tick();
        check("post_rst_gnt", gnt4, 4'b0010);
        req4 = '0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (rv4) begin
                lat = c;
                break;
            end
        end
        check("post_rst_lat", lat, 4);
        check("post_rst_id", id4, 1);
        check("post_rst_data", rd4, 8'h3C);

        // EXEC_CYCLES=1 back-to-back with req held high
        req1 = 4'b0100;
        dat1 = 32'h0012_0000;
        ng = 0;
        nr = 0;
        consec = 0;
        prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt1 != 0 && ng < 8) begin
                g_id[ng]  = oh2i(gnt1);
                g_cyc[ng] = c;
                ng++;
            end
            if (rv1) begin
                if (prev) consec++;
                if (nr < 8) begin
                    r_id[nr]  = id1;
                    r_dat[nr] = rd1;
                    r_cyc[nr] = c;
                    nr++;
                end
            end
            prev = rv1;
        end
        req1 = '0;
        repeat (4) tick();
        check("b2b_grants_min", (ng >= 4), 1);
        check("b2b_results_min", (nr >= 4), 1);
        check("b2b_consec_rv", consec, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) check($sformatf("b2b_gnt_id%0d", i), g_id[i], 2);
            if (i > 0 && i < ng) check($sformatf("b2b_gap%0d", i), g_cyc[i] - g_cyc[i-1], 3);
            if (i < ng && i < nr) begin
                check($sformatf("b2b_lat%0d", i), r_cyc[i] - g_cyc[i], 1);
                check($sformatf("b2b_id%0d", i), r_id[i], 2);
                check($sformatf("b2b_dat%0d", i), r_dat[i], 8'hED);
            end
        end
        check("b2b_final_idle", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_share_arbiter.md
# inv_share_arbiter

Round-robin arbiter and sequencer that shares one bitwise-inversion unit among N requesters. Each requester raises a request with a W-bit operand. The block grants one requester at a time, runs the operand through the inverter for a fixed number of execution cycles, and returns the inverted result tagged with the requester's index. It sits between the requesting logic and the inverter datapath, and it is the only path into that datapath.

## Interface
Parameters:
- N, 4: number of requesters, N ≥ 2
- W, 8: operand/result width in bits
- EXEC_CYCLES, 2: cycles the shared inverter is occupied per operation, ≥ 1

Ports (clock and reset first):
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N  per-requester request; bit i = requester i
- req_data  input  N*W  operands; requester i uses bits [i*W +: W]
- gnt  output  N  one-hot grant, high for exactly one cycle
- busy  output  1  high while an operation is in flight (state ≠ IDLE)
- resp_valid  output  1  one-cycle result strobe
- resp_id  output  clog2(N)  index of the requester that owns the result
- resp_data  output  W  inverted operand (~operand)

## Operation
- FSM has three states:
  - IDLE: waits for a request.
  - EXEC: the inverter is occupied; the counter runs.
  - DONE: the result is presented for one cycle.
- IDLE with req ≠ 0, at the clock edge:
  - pick the winner: the first set bit of req searching ptr+1, ptr+2, … mod N
  - gnt ← onehot(winner); data_q ← the winner's req_data slice; ptr ← winner
  - cnt ← EXEC_CYCLES−1; state ← EXEC
- EXEC, each edge:
  - gnt ← 0, so gnt is high for exactly one cycle
  - if cnt == 0: resp_data ← ~data_q, resp_id ← ptr, resp_valid ← 1, state ← DONE
  - otherwise cnt ← cnt−1
- DONE, next edge: resp_valid ← 0; state ← IDLE. resp_data and resp_id hold their values until the next result.
- IDLE with req == 0: no state change; gnt stays 0.
- req and req_data are sampled only in IDLE. Changes during EXEC or DONE are ignored; there is no cancel.
- Requester obligations:
  - hold req and req_data stable until gnt is seen
  - drop req in the cycle after gnt, unless it wants another operation
  - a req still high when the block returns to IDLE is a new request and competes normally
- Fairness: the last winner has the lowest priority at the next arbitration. A continuously requesting port waits at most N−1 operations.
- Reset values: state IDLE, ptr N−1 (so requester 0 wins first), cnt 0, gnt 0, busy 0, resp_valid 0, resp_id 0, resp_data 0.
- Reset mid-operation: the in-flight operation is discarded, no resp_valid is produced, and arbitration restarts from requester 0.

## Timing
- Request sampled at edge k (IDLE):
  - gnt high for the cycle after edge k
  - busy high from edge k until edge k+EXEC_CYCLES+1
  - resp_valid high for the cycle after edge k+EXEC_CYCLES
- Grant-to-result latency: resp_valid rises EXEC_CYCLES cycles after gnt rises.
- Maximum throughput: one operation per EXEC_CYCLES+2 cycles. The next grant can occur at edge k+EXEC_CYCLES+2 at the earliest.
- busy is decoded from the state register; no combinational path from req to any output.
- rst has priority over all other transitions on the same edge.

## Test plan
- Single request, N=4, W=8, EXEC_CYCLES=2: req=0001, req_data[7:0]=0xA5 sampled at edge k:
  - gnt=0001 for one cycle
  - resp_valid at edge k+2 with resp_id=0, resp_data=0x5A
  - busy deasserts after edge k+3
- All four requesting continuously, operands 0x00/0xFF/0x0F/0xF0:
  - grant order 0,1,2,3,0
  - results 0xFF/0x00/0xF0/0x0F with matching resp_id
  - grants exactly 4 cycles apart
- Wrap-around: after requester 3 wins, req=1010 → requester 1 wins (search wraps 0,1). Then req=1000 only → requester 3 wins.
- Reset mid-EXEC, EXEC_CYCLES=4: assert rst for one cycle two cycles after gnt:
  - no resp_valid
  - all outputs return to 0
  - a new req=0110 grants requester 1
- Back-to-back, EXEC_CYCLES=1, req=0100 held high:
  - gnt every 3 cycles
  - each resp_valid arrives 1 cycle after its gnt
  - resp_valid is never high for two consecutive cycles
- Late data change: alter req_data of the granted port during EXEC → resp_data reflects the operand sampled at grant time.
